// File: rtl/bcom_pkg.sv
// Shared command codes and the FSM state type for the byte-command register bank.
package bcom_pkg;

  localparam logic [7:0] CMD_WR   = 8'h0F;
  localparam logic [7:0] CMD_RD   = 8'hF0;
  localparam logic [7:0] CMD_WRA  = 8'h3C;
  localparam logic [7:0] CMD_RDA  = 8'hC3;
  localparam logic [7:0] NAK_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WA_ADDR,
    WA_DATA,
    RA_ADDR,
    TX_PULSE,
    TX_GUARD,
    TX_WAIT
  } bcom_state_t;

endpackage

// File: rtl/bcom_tx_hs.sv
// Transmit handshake: latches one byte, strobes it once, then waits for the UART to go idle.
module bcom_tx_hs
  import bcom_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       txbusy,
  output logic [7:0] txdw,
  output logic       txena,
  output logic       done
);
  // state    | meaning
  // IDLE     | no byte in flight, waiting for load
  // TX_PULSE | strobe cycle, txdw valid
  // TX_GUARD | one cycle letting the UART raise busy
  // TX_WAIT  | holding txdw until busy falls

  bcom_state_t st_q, st_d;
  logic [7:0]  txdw_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      txdw_q <= '0;
    end else begin
      st_q <= st_d;
      if (load && st_q == IDLE) txdw_q <= data;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:     if (load) st_d = TX_PULSE;
      TX_PULSE: st_d = TX_GUARD;
      TX_GUARD: st_d = TX_WAIT;
      TX_WAIT:  if (!txbusy) st_d = IDLE;
      default:  st_d = IDLE;
    endcase
  end

  always_comb begin
    txena = (st_q == TX_PULSE);
    done  = (st_q == TX_WAIT) && !txbusy;
    txdw  = txdw_q;
  end

endmodule

// File: rtl/bcom_regbank.sv
// Byte-command interpreter: decodes UART frames into a shadowed, atomically committed register file.
module bcom_regbank
  import bcom_pkg::*;
#(
  parameter int                  NBYTES    = 11,
  parameter int                  TOUT_CLKS = 100000,
  parameter logic [8*NBYTES-1:0] RST_VAL   = '0
) (
  input  logic                  clk,
  input  logic                  ic_rst,
  input  logic [7:0]            id_rxdw,
  input  logic                  ic_rxrdy,
  input  logic                  ic_txbusy,
  output logic [7:0]            od_txdw,
  output logic                  oc_txena,
  output logic [8*NBYTES-1:0]   od_regs,
  output logic                  oc_upd,
  output logic                  oc_frame_err
);
  // state    | meaning
  // IDLE     | waiting for a command byte
  // WR_DATA  | collecting bulk-write bytes into the shadow
  // WA_ADDR  | addressed write, waiting for the address
  // WA_DATA  | addressed write, waiting for the data
  // RA_ADDR  | addressed read, waiting for the address
  // TX_PULSE | response in progress, owned by bcom_tx_hs

  localparam int              CW   = $clog2(NBYTES + 1);
  localparam int              TW   = $clog2(TOUT_CLKS + 1);
  localparam logic [CW-1:0]   LAST = CW'(NBYTES - 1);

  bcom_state_t   state_q, state_d;
  logic          rxrdy_q, rx_acc, wait_st, tout_hit, addr_ok, tx_done, more_rd;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] tout_q;
  logic [7:0]    regs_q   [NBYTES];
  logic [7:0]    shadow_q [NBYTES];
  logic [7:0]    addr_q, txd_q, rd_sel, rd_byte;
  logic          is_rd_q, load_q, commit_q, upd_q, err_q;
  logic          load_d, tx_nak, err_d, commit_d, cnt_clr, cnt_inc, wr_bulk, wr_addr, addr_ld;

  assign rx_acc   = ic_rxrdy && !rxrdy_q;
  assign wait_st  = state_q inside {WR_DATA, WA_ADDR, WA_DATA, RA_ADDR};
  assign tout_hit = wait_st && (tout_q == '0);
  assign addr_ok  = int'({24'd0, id_rxdw}) < NBYTES;
  assign more_rd  = is_rd_q && (cnt_q != LAST);

  always_ff @(posedge clk) begin
    if (ic_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (rx_acc) begin
        unique case (id_rxdw)
          CMD_WR:  state_d = WR_DATA;
          CMD_WRA: state_d = WA_ADDR;
          CMD_RDA: state_d = RA_ADDR;
          default: state_d = TX_PULSE;
        endcase
      end
      WR_DATA: if ((rx_acc && cnt_q == LAST) || (!rx_acc && tout_hit)) state_d = IDLE;
      WA_ADDR: if (rx_acc) state_d = addr_ok ? WA_DATA : TX_PULSE;
               else if (tout_hit) state_d = IDLE;
      WA_DATA: if (rx_acc || tout_hit) state_d = IDLE;
      RA_ADDR: if (rx_acc) state_d = TX_PULSE;
               else if (tout_hit) state_d = IDLE;
      default: if (tx_done && !more_rd) state_d = IDLE;
    endcase
  end

  always_comb begin
    load_d = 1'b0; tx_nak = 1'b0; err_d = 1'b0; commit_d = 1'b0; rd_sel = '0;
    cnt_clr = 1'b0; cnt_inc = 1'b0; wr_bulk = 1'b0; wr_addr = 1'b0; addr_ld = 1'b0;
    unique case (state_q)
      IDLE: if (rx_acc) begin
        unique case (id_rxdw)
          CMD_WR:           cnt_clr = 1'b1;
          CMD_RD:           begin cnt_clr = 1'b1; load_d = 1'b1; end
          CMD_WRA, CMD_RDA: ;
          default:          begin load_d = 1'b1; tx_nak = 1'b1; err_d = 1'b1; end
        endcase
      end
      WR_DATA: if (rx_acc) begin
        wr_bulk  = 1'b1;
        cnt_inc  = 1'b1;
        commit_d = (cnt_q == LAST);
      end else err_d = tout_hit;
      WA_ADDR: if (rx_acc) begin
        addr_ld = addr_ok;
        load_d  = !addr_ok;
        tx_nak  = !addr_ok;
        err_d   = !addr_ok;
      end else err_d = tout_hit;
      WA_DATA: if (rx_acc) begin
        wr_addr  = 1'b1;
        commit_d = 1'b1;
      end else err_d = tout_hit;
      RA_ADDR: if (rx_acc) begin
        load_d = 1'b1;
        rd_sel = id_rxdw;
        tx_nak = !addr_ok;
        err_d  = !addr_ok;
      end else err_d = tout_hit;
      default: if (tx_done && more_rd) begin
        load_d  = 1'b1;
        cnt_inc = 1'b1;
        rd_sel  = 8'(cnt_q) + 8'd1;
      end
    endcase
  end

  always_comb begin
    rd_byte = '0;
    for (int i = 0; i < NBYTES; i++)
      if (rd_sel == 8'(i)) rd_byte = regs_q[i];
  end

  always_ff @(posedge clk) begin
    if (ic_rst) begin
      rxrdy_q <= 1'b0; cnt_q <= '0; tout_q <= '0; addr_q <= '0; txd_q <= '0;
      is_rd_q <= 1'b0; load_q <= 1'b0; commit_q <= 1'b0; upd_q <= 1'b0; err_q <= 1'b0;
      for (int i = 0; i < NBYTES; i++) begin
        regs_q[i]   <= RST_VAL[8*i +: 8];
        shadow_q[i] <= '0;
      end
    end else begin
      rxrdy_q  <= ic_rxrdy;
      load_q   <= load_d;
      err_q    <= err_d;
      commit_q <= commit_d;
      upd_q    <= commit_q;
      if (load_d) txd_q <= tx_nak ? NAK_BYTE : rd_byte;
      if (state_q == IDLE && rx_acc) is_rd_q <= (id_rxdw == CMD_RD);
      if (addr_ld) addr_q <= id_rxdw;
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CW'(1);
      // Timer reloads on every byte; it only counts down while a frame is open.
      if (rx_acc)                        tout_q <= TW'(TOUT_CLKS);
      else if (wait_st && tout_q != '0) tout_q <= tout_q - TW'(1);
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_bulk && cnt_q == CW'(i)) shadow_q[i] <= id_rxdw;
        if (wr_addr) shadow_q[i] <= (addr_q == 8'(i)) ? id_rxdw : regs_q[i];
        if (tout_hit && !rx_acc) shadow_q[i] <= '0;
        if (commit_q) regs_q[i] <= shadow_q[i];
      end
    end
  end

  bcom_tx_hs u_tx_hs (
    .clk    (clk),
    .rst    (ic_rst),
    .load   (load_q),
    .data   (txd_q),
    .txbusy (ic_txbusy),
    .txdw   (od_txdw),
    .txena  (oc_txena),
    .done   (tx_done)
  );

  for (genvar g = 0; g < NBYTES; g++) begin : g_regs
    assign od_regs[8*g +: 8] = regs_q[g];
  end

  assign oc_upd       = upd_q;
  assign oc_frame_err = err_q;

endmodule

// File: tb/tb_bcom_regbank.sv
// Directed/randomized bench for bcom_regbank with a byte-array reference model and a UART TX model.
module tb_bcom_regbank;
  localparam int            NB   = 11;
  localparam int            TOUT = 300;
  localparam logic [8*NB-1:0] RSTV = 88'h5A_00_11_22_33_44_55_66_77_88_99;

  logic            clk = 1'b0, ic_rst = 1'b1, ic_rxrdy = 1'b0, ic_txbusy = 1'b0;
  logic [7:0]      id_rxdw = '0;
  logic [7:0]      od_txdw;
  logic            oc_txena, oc_upd, oc_frame_err;
  logic [8*NB-1:0] od_regs;

  always #5 clk = ~clk;

  bcom_regbank #(.NBYTES(NB), .TOUT_CLKS(TOUT), .RST_VAL(RSTV)) dut (
    .clk(clk), .ic_rst(ic_rst), .id_rxdw(id_rxdw), .ic_rxrdy(ic_rxrdy), .ic_txbusy(ic_txbusy),
    .od_txdw(od_txdw), .oc_txena(oc_txena), .od_regs(od_regs), .oc_upd(oc_upd),
    .oc_frame_err(oc_frame_err)
  );

  logic [7:0] model [NB];
  logic [7:0] tx_q [$];
  logic [7:0] last_tx = '0;
  int upd_cnt = 0, err_cnt = 0, busy_viol = 0, hold_viol = 0, busy_left = 0;
  int n_cmp = 0, n_err = 0;

  // UART transmitter model: busy for 10 clocks after each strobe; also records strobes and pulses.
  always @(negedge clk) begin
    if (oc_upd) upd_cnt++;
    if (oc_frame_err) err_cnt++;
    if (ic_txbusy && od_txdw !== last_tx) hold_viol++;
    if (oc_txena) begin
      if (ic_txbusy) busy_viol++;
      tx_q.push_back(od_txdw);
      last_tx   = od_txdw;
      busy_left = 10;
    end else if (busy_left > 0) busy_left--;
    ic_txbusy = (busy_left > 0);
  end

  function automatic logic [8*NB-1:0] packm();
    logic [8*NB-1:0] v;
    for (int i = 0; i < NB; i++) v[8*i +: 8] = model[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    id_rxdw  = b;
    ic_rxrdy = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    ic_rxrdy = 1'b0;
    repeat ($urandom_range(1, 2)) @(negedge clk);
  endtask

  task automatic wait_tx(input int n, input string tag);
    int cyc = 0;
    while (tx_q.size() < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (16) @(negedge clk);
    chk({tag, "_count"}, tx_q.size(), n);
  endtask

  task automatic check_bulk_read(input string tag);
    tx_q.delete();
    send_byte(8'hF0);
    wait_tx(NB, tag);
    for (int i = 0; i < NB; i++)
      chk(tag, (i < tx_q.size()) ? tx_q[i] : 8'hxx, model[i]);
  endtask

  initial begin
    int u0, e0, a, cyc;
    logic [7:0] d;
    logic [8*NB-1:0] snap;

    for (int i = 0; i < NB; i++) model[i] = RSTV[8*i +: 8];
    repeat (3) @(negedge clk);
    chk("rst_regs", od_regs, RSTV);
    chk("rst_txena", oc_txena, 1'b0);
    chk("rst_upd", oc_upd, 1'b0);
    chk("rst_err", oc_frame_err, 1'b0);
    chk("rst_txdw", od_txdw, 8'h00);
    ic_rst = 1'b0;
    @(negedge clk);

    // Bulk write 01..0B with exact commit latency on the final byte.
    u0 = upd_cnt; e0 = err_cnt; snap = packm();
    send_byte(8'h0F);
    for (int i = 0; i < NB - 1; i++) send_byte(8'(i + 1));
    @(negedge clk); id_rxdw = 8'h0B; ic_rxrdy = 1'b1;
    @(negedge clk);
    chk("commit_not_early", od_regs, snap);
    chk("upd_not_early", oc_upd, 1'b0);
    ic_rxrdy = 1'b0;
    @(negedge clk);
    chk("commit_regs", od_regs, 88'h0B0A090807060504030201);
    chk("commit_upd", oc_upd, 1'b1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < NB; i++) model[i] = 8'(i + 1);
    chk("bulk_upd_count", upd_cnt - u0, 1);
    chk("bulk_err_count", err_cnt - e0, 0);

    // Bulk read with a stray byte sent mid-response, which must be ignored.
    tx_q.delete(); e0 = err_cnt;
    send_byte(8'hF0);
    cyc = 0;
    while (tx_q.size() < 1 && cyc < 200) begin @(negedge clk); cyc++; end
    send_byte(8'h77);
    wait_tx(NB, "bulk_rd");
    for (int i = 0; i < NB; i++)
      chk("bulk_rd_byte", (i < tx_q.size()) ? tx_q[i] : 8'hxx, model[i]);
    chk("stray_byte_no_err", err_cnt - e0, 0);

    // Addressed write 3C 04 5A, read back C3 04, then random addressed traffic.
    u0 = upd_cnt;
    send_byte(8'h3C); send_byte(8'h04); send_byte(8'h5A);
    repeat (3) @(negedge clk);
    model[4] = 8'h5A;
    chk("wa_regs", od_regs, packm());
    tx_q.delete();
    send_byte(8'hC3); send_byte(8'h04);
    wait_tx(1, "ra");
    chk("ra_byte", tx_q[0], 8'h5A);
    for (int k = 0; k < 6; k++) begin
      a = $urandom_range(0, NB - 1);
      d = 8'($urandom);
      send_byte(8'h3C); send_byte(8'(a)); send_byte(d);
      repeat (3) @(negedge clk);
      model[a] = d;
      chk("wa_rand_regs", od_regs, packm());
      a = $urandom_range(0, NB - 1);
      tx_q.delete();
      send_byte(8'hC3); send_byte(8'(a));
      wait_tx(1, "ra_rand");
      chk("ra_rand_byte", tx_q[0], model[a]);
    end
    chk("wa_upd_count", upd_cnt - u0, 7);

    // Bad addresses and an unknown command: NAKs and frame errors, no register change.
    tx_q.delete(); e0 = err_cnt; u0 = upd_cnt; snap = packm();
    send_byte(8'h3C); send_byte(8'(NB));
    wait_tx(1, "nak_wa");
    send_byte(8'h77);
    wait_tx(2, "nak_cmd");
    send_byte(8'hC3); send_byte(8'($urandom_range(NB, 255)));
    wait_tx(3, "nak_ra");
    for (int i = 0; i < 3; i++)
      chk("nak_byte", (i < tx_q.size()) ? tx_q[i] : 8'hxx, 8'hEE);
    chk("nak_err_count", err_cnt - e0, 3);
    chk("nak_no_upd", upd_cnt - u0, 0);
    chk("nak_regs", od_regs, snap);

    // Partial bulk write then silence: timeout must not fire early, then fire once.
    e0 = err_cnt; u0 = upd_cnt;
    send_byte(8'h0F);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    repeat (TOUT - 10) @(negedge clk);
    chk("tout_not_early", err_cnt - e0, 0);
    repeat (14) @(negedge clk);
    chk("tout_err_count", err_cnt - e0, 1);
    chk("tout_no_upd", upd_cnt - u0, 0);
    chk("tout_regs", od_regs, packm());
    check_bulk_read("tout_rd_byte");

    // Reset in the middle of a bulk write, then a complete random frame.
    send_byte(8'h0F);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    u0 = upd_cnt;
    ic_rst = 1'b1;
    repeat (2) @(negedge clk);
    ic_rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NB; i++) model[i] = RSTV[8*i +: 8];
    chk("midrst_regs", od_regs, RSTV);
    chk("midrst_no_upd", upd_cnt - u0, 0);
    send_byte(8'h0F);
    for (int i = 0; i < NB; i++) begin
      model[i] = 8'($urandom);
      send_byte(model[i]);
    end
    repeat (3) @(negedge clk);
    chk("newframe_regs", od_regs, packm());
    chk("newframe_upd", upd_cnt - u0, 1);
    check_bulk_read("final_rd_byte");

    chk("txena_while_busy", busy_viol, 0);
    chk("txdw_hold", hold_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcom_regbank.md
# bcom_regbank

Parametrised byte-command configuration interpreter. It sits between the UART receiver/transmitter byte interfaces and the datapath configuration registers. Compared with the fixed 11-byte configuration block, it adds a generic register file of `NBYTES` bytes, addressed single-byte write and read commands, atomic (shadowed) bulk updates, inter-byte timeout recovery, and NAK responses on errors. The legacy bulk write (`0x0F`) and bulk read (`0xF0`) frames remain bit-compatible.

## Interface
Parameters:
- `NBYTES`, default 11: number of register bytes, range 1..255.
- `TOUT_CLKS`, default 100000: inter-byte timeout in clocks for frames already in progress.
- `RST_VAL`, default all zeros: reset value of the register file, `8*NBYTES` bits wide.

Ports:
- `clk`  in  1  system clock. There is one clock; reset is synchronous and active-high.
- `ic_rst`  in  1  synchronous active-high reset.
- `id_rxdw`  in  8  received byte. It is valid when `ic_rxrdy` rises.
- `ic_rxrdy`  in  1  receive-ready. Acceptance is edge-detected, so one byte is taken per 0→1 transition.
- `ic_txbusy`  in  1  the transmitter is busy.
- `od_txdw`  out  8  byte to transmit. It is held stable from the `oc_txena` pulse until `ic_txbusy` falls.
- `oc_txena`  out  1  one-cycle transmit strobe.
- `od_regs`  out  `8*NBYTES`  register file. Register byte i occupies bits [8i+7:8i].
- `oc_upd`  out  1  one-cycle pulse whenever `od_regs` changes.
- `oc_frame_err`  out  1  one-cycle pulse on a timeout, an unknown command, or a bad address.

## Operation
Commands. The first accepted byte in IDLE is the command:
- `0x0F`, bulk write: the next `NBYTES` bytes fill the shadow at indices 0..`NBYTES`-1 in order. The shadow is committed to `od_regs` after the last byte. No response is sent.
- `0xF0`, bulk read: transmits reg[0]..reg[`NBYTES`-1] in order.
- `0x3C`, addressed write: the next two bytes are the address, then the data. If the address is less than `NBYTES`, reg[addr] is written and `oc_upd` pulses. Otherwise the write is dropped, NAK `0xEE` is sent, and `oc_frame_err` pulses.
- `0xC3`, addressed read: the next byte is the address. If it is in range, reg[addr] is transmitted; otherwise NAK is sent.
- Any other command: NAK is sent and `oc_frame_err` pulses.

States:
- IDLE
- WR_DATA
- WA_ADDR
- WA_DATA
- RA_ADDR
- TX_PULSE
- TX_GUARD
- TX_WAIT

Rules:
- The byte counter is `$clog2(NBYTES+1)` bits wide. It clears on entry to WR_DATA and on entry to the bulk-read TX sequence.
- Timeout: a counter runs in WR_DATA, WA_ADDR, WA_DATA and RA_ADDR, and clears on every accepted byte. When it reaches `TOUT_CLKS`, the shadow is discarded, `od_regs` is left unchanged, `oc_frame_err` pulses, and the state returns to IDLE. The timeout is not active in IDLE or in the TX states.
- Bytes arriving in any TX state are ignored. They are not queued and do not raise an error.
- `ic_rst` in any state: the FSM returns to IDLE, the shadow and counters clear, and `od_regs` reloads `RST_VAL`. No `oc_upd` pulse is produced for the reset.
- Reset values: `od_txdw` = 0, `oc_txena` = 0, `oc_upd` = 0, `oc_frame_err` = 0, `od_regs` = `RST_VAL`.

## Timing
- A byte is accepted at edge N when `ic_rxrdy` is 1 at N and was 0 at N-1. A level held high for several cycles counts as one byte.
- Commit: if the last bulk-write byte (or the addressed-write data byte) is accepted at edge N, `od_regs` takes its new value at edge N+1 and `oc_upd` is high for the cycle after N+1.
- Transmit: the command or address completes at edge N. `od_txdw` is loaded at N+1, and `oc_txena` is high for exactly the cycle following N+1.
- TX_GUARD lasts one cycle after the pulse, during which `ic_txbusy` is ignored. TX_WAIT holds until `ic_txbusy` = 0. The next byte then loads and pulses as above.
- `oc_txena` is never asserted while `ic_txbusy` = 1.
- Back-to-back commands are legal. A command byte accepted on the cycle IDLE is re-entered is decoded normally.
- `oc_frame_err` for an address error pulses in the cycle after the address byte is accepted, concurrent with the NAK load.

## Structure
- Package `bcom_pkg` contains:
  - command constants `CMD_WR`, `CMD_RD`, `CMD_WRA`, `CMD_RDA`;
  - `NAK_BYTE`;
  - the state enum `bcom_state_t`.
- Sub-module `bcom_tx_hs` owns the TX_PULSE/TX_GUARD/TX_WAIT handshake and `od_txdw` holding. It takes a `load` and `data` input and returns a `done` output.
- The top level contains the receive edge detector, command FSM, shadow, register file and timeout counter.

## Test plan
- Reset, then bulk write `0x0F`, 01..0B → `od_regs` = `0x0B0A090807060504030201`, and exactly one `oc_upd` pulse.
- Bulk read `0xF0` with the transmitter model raising busy for 10 clocks after each strobe → 11 `oc_txena` pulses carrying 01..0B in order, none of them while busy.
- Addressed write `0x3C`, 04, `0x5A`, then addressed read `0xC3`, 04 → reg[4] = `0x5A`, the rest unchanged, and one transmitted byte `0x5A`.
- Addressed write with address `0x0B` (= `NBYTES`), then unknown command `0x77` → two NAKs of `0xEE`, two `oc_frame_err` pulses, and `od_regs` unchanged.
- Bulk write of 5 bytes, then silence for `TOUT_CLKS`+2 clocks → `oc_frame_err` pulses once, there is no `oc_upd`, and the next `0xF0` returns the previous values.
- Assert `ic_rst` mid bulk-write at byte 6, then send a full new frame → `od_regs` = `RST_VAL` after reset, then the new frame's values after commit.
